uart_bus_bridge: RTL and testbench

Debug/bootload bridge and bus initiator driven by a UART byte stream. It consumes command frames from a UART receiver's byte handshake and issues single-word read/write transactions on the core-side memory-mapped bus. It returns response bytes to a UART transmitter's byte handshake. It sits between an on-chip uart instance and the SoC bus, letting a host load memory and poke peripherals without the CPU.

---
 rtl/uart_bus_bridge.sv | 162 ++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// UART command-frame bridge: issues single-word bus reads/writes and returns ACK/NAK/read bytes.
// Optional inter-byte timeout in ADDR/DATA is enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_bus_bridge #(
  parameter logic [7:0] CMD_WRITE = 8'h57,
  parameter logic [7:0] CMD_READ  = 8'h52,
  parameter logic [7:0] ACK_BYTE  = 8'h06,
  parameter logic [7:0] NAK_BYTE  = 8'h15
`ifdef UART_BRIDGE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1_250_000
`endif
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_write_o,
  output logic        bus_read_o,
  output logic [3:0]  bus_size_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [3:0] {
    IDLE, ADDR, DATA, BUS_WR, BUS_RD, RD_WAIT, RESP, ACK, NAK
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_nxt;
  logic        is_write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        in_frame;
  logic        rx_accept;
  logic        tmo_hit;

  assign in_frame   = (state_q == ADDR) || (state_q == DATA);
  assign rx_ready_o = (state_q == IDLE) || in_frame;
  assign rx_accept  = rx_valid_i && rx_ready_o;
  assign cnt_nxt    = cnt_q + 2'd1;

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  // An accepted byte always wins over an expiring timer in the same cycle.
  assign tmo_hit = in_frame && !rx_accept && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (!in_frame || rx_accept || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      tx_data_o   <= '0;
      tx_valid_o  <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_write_o <= 1'b0;
      bus_read_o  <= 1'b0;
      bus_size_o  <= '0;
    end else begin
      bus_write_o <= 1'b0;
      bus_read_o  <= 1'b0;
      bus_size_o  <= '0;
      case (state_q)
        IDLE: if (rx_accept) begin
          if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
            is_write_q <= (rx_data_i == CMD_WRITE);
            cnt_q      <= '0;
            state_q    <= ADDR;
          end else begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= NAK_BYTE;
            state_q    <= NAK;
          end
        end
        ADDR: if (tmo_hit) begin
          state_q <= IDLE;
        end else if (rx_accept) begin
          addr_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
          cnt_q <= cnt_nxt;
          if (cnt_q == 2'd3) begin
            if (is_write_q) begin
              state_q <= DATA;
            end else begin
              // Strobe fires the cycle after the last byte, so merge that byte in directly.
              bus_addr_o <= {rx_data_i, addr_q[23:0]};
              bus_read_o <= 1'b1;
              bus_size_o <= 4'b1111;
              state_q    <= BUS_RD;
            end
          end
        end
        DATA: if (tmo_hit) begin
          state_q <= IDLE;
        end else if (rx_accept) begin
          wdata_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
          cnt_q <= cnt_nxt;
          if (cnt_q == 2'd3) begin
            bus_addr_o  <= addr_q;
            bus_wdata_o <= {rx_data_i, wdata_q[23:0]};
            bus_write_o <= 1'b1;
            bus_size_o  <= 4'b1111;
            state_q     <= BUS_WR;
          end
        end
        BUS_WR: begin
          tx_valid_o <= 1'b1;
          tx_data_o  <= ACK_BYTE;
          state_q    <= ACK;
        end
        BUS_RD: state_q <= RD_WAIT;
        RD_WAIT: begin
          rdata_q    <= bus_rdata_i;
          tx_valid_o <= 1'b1;
          tx_data_o  <= bus_rdata_i[7:0];
          cnt_q      <= '0;
          state_q    <= RESP;
        end
        RESP: if (tx_ready_i) begin
          cnt_q <= cnt_nxt;
          if (cnt_q == 2'd3) begin
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            state_q    <= IDLE;
          end else begin
            tx_data_o <= rdata_q[{cnt_nxt, 3'b000} +: 8];
          end
        end
        ACK, NAK: if (tx_ready_i) begin
          tx_valid_o <= 1'b0;
          tx_data_o  <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: frame table plus backpressure, mid-frame reset and timeout sequences.
module tb_uart_bus_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] bus_addr_o;
  logic        bus_write_o;
  logic        bus_read_o;
  logic [3:0]  bus_size_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;

  always #5 clk_i = ~clk_i;

`ifdef UART_BRIDGE_TIMEOUT_EN
  uart_bus_bridge #(.TIMEOUT_CYCLES(100)) dut (
`else
  uart_bus_bridge dut (
`endif
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .bus_addr_o(bus_addr_o), .bus_write_o(bus_write_o), .bus_read_o(bus_read_o),
    .bus_size_o(bus_size_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i)
  );

  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] wdata; } bus_exp_t;
  typedef struct { logic [7:0] cmd; int strobe; logic [31:0] addr; logic [31:0] data; logic [7:0] rsp; } vec_t;

  bus_exp_t   exp_bus[$];
  logic [7:0] exp_tx[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  logic [31:0] rd_value = '0;
  bit rd_arm = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Bus slave: read data is valid only during the cycle after the read strobe.
  initial bus_rdata_i = 32'hDEAD_BEEF;
  always @(posedge clk_i) begin
    #1;
    if (rd_arm) begin
      bus_rdata_i = rd_value;
      rd_arm = 1'b0;
    end else begin
      bus_rdata_i = 32'hDEAD_BEEF;
    end
    if (bus_read_o) rd_arm = 1'b1;
  end

  // Monitor / scoreboard, sampling after inputs for the coming edge have settled.
  bit         prev_txv, prev_rdy, prev_strobe, rise_pending;
  logic [7:0] prev_dat;
  int         rise_cyc;
  always @(negedge clk_i) begin
    bus_exp_t e;
    #1;
    if (!rst_ni) begin
      prev_txv = 0; prev_rdy = 0; prev_strobe = 0; rise_pending = 0;
    end else begin
      if (prev_txv && !prev_rdy) begin
        chk("tx_valid held", {31'b0, tx_valid_o}, 32'd1);
        chk("tx_data held", {24'b0, tx_data_o}, {24'b0, prev_dat});
      end
      if (tx_valid_o) chk("rx_ready while responding", {31'b0, rx_ready_o}, 32'd0);
      if (bus_write_o || bus_read_o) begin
        chk("strobe back-to-back", {31'b0, prev_strobe}, 32'd0);
        chk("strobe exclusive", {31'b0, bus_write_o & bus_read_o}, 32'd0);
        chk("strobe size", {28'b0, bus_size_o}, 32'hF);
        chk("strobe latency", cyc, last_acc_cyc + 1);
        if (exp_bus.size() == 0) fail_event("unexpected strobe");
        else begin
          e = exp_bus.pop_front();
          chk("strobe kind", {31'b0, bus_write_o}, {31'b0, e.wr});
          chk("bus addr", bus_addr_o, e.addr);
          if (e.wr) chk("bus wdata", bus_wdata_o, e.wdata);
        end
        rise_pending = 1;
        rise_cyc = cyc + (bus_write_o ? 1 : 2);
      end else begin
        chk("size idle", {28'b0, bus_size_o}, 32'd0);
      end
      if (tx_valid_o && !prev_txv) begin
        if (rise_pending) chk("tx latency after strobe", cyc, rise_cyc);
        else              chk("tx latency after nak", cyc, last_acc_cyc + 1);
        rise_pending = 0;
      end
      if (tx_valid_o && tx_ready_i) begin
        if (exp_tx.size() == 0) fail_event("unexpected tx byte");
        else chk("tx byte", {24'b0, tx_data_o}, {24'b0, exp_tx.pop_front()});
      end
      prev_txv = tx_valid_o;
      prev_rdy = tx_ready_i;
      prev_dat = tx_data_o;
      prev_strobe = bus_write_o | bus_read_o;
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    rx_data_i = b;
    rx_valid_i = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (rx_ready_o) begin
        ok = 1;
        last_acc_cyc = cyc;
      end
      @(negedge clk_i);
    end
    rx_valid_i = 1'b0;
    if (!ok) fail_event("rx accept timeout");
    repeat ($urandom_range(0, 2)) @(negedge clk_i);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic expect_read(input logic [31:0] addr, input logic [31:0] data);
    exp_bus.push_back('{1'b0, addr, 32'h0});
    rd_value = data;
    for (int k = 0; k < 4; k++) exp_tx.push_back(data[8*k +: 8]);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk_i);
      if (exp_tx.size() == 0 && exp_bus.size() == 0 && !tx_valid_o) done = 1;
    end
    chk("frame drained", {31'b0, done}, 32'd1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " tx_valid"}, {31'b0, tx_valid_o}, 32'd0);
    chk({tag, " tx_data"}, {24'b0, tx_data_o}, 32'd0);
    chk({tag, " bus_write"}, {31'b0, bus_write_o}, 32'd0);
    chk({tag, " bus_read"}, {31'b0, bus_read_o}, 32'd0);
    chk({tag, " bus_size"}, {28'b0, bus_size_o}, 32'd0);
    chk({tag, " bus_addr"}, bus_addr_o, 32'd0);
    chk({tag, " bus_wdata"}, bus_wdata_o, 32'd0);
    chk({tag, " rx_ready"}, {31'b0, rx_ready_o}, 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h57, 1, 32'h8000_0008, 32'h0000_0041, 8'h06};
    vecs[1] = '{8'h52, 2, 32'h8000_0004, 32'h1234_56A5, 8'h00};
    vecs[2] = '{8'h3F, 0, 32'h0,         32'h0,         8'h15};
    vecs[3] = '{8'h52, 2, 32'h0000_0000, 32'hA5A5_0FF0, 8'h00};
    vecs[4] = '{8'h57, 1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 8'h06};
    vecs[5] = '{8'h00, 0, 32'h0,         32'h0,         8'h15};
    vecs[6] = '{8'h52, 2, 32'hFFFF_FFFF, 32'h8000_0001, 8'h00};
    vecs[7] = '{8'h77, 0, 32'h0,         32'h0,         8'h15};

    rst_ni = 1'b1; rx_data_i = '0; rx_valid_i = 1'b0; tx_ready_i = 1'b1;
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].strobe == 1) begin
        exp_bus.push_back('{1'b1, vecs[i].addr, vecs[i].data});
        exp_tx.push_back(vecs[i].rsp);
      end else if (vecs[i].strobe == 2) begin
        expect_read(vecs[i].addr, vecs[i].data);
      end else begin
        exp_tx.push_back(vecs[i].rsp);
      end
      send_byte(vecs[i].cmd);
      if (vecs[i].strobe != 0) send_word(vecs[i].addr);
      if (vecs[i].strobe == 1) send_word(vecs[i].data);
      wait_drain();
    end

    // Read response held off by the transmitter for 20 cycles.
    tx_ready_i = 1'b0;
    expect_read(32'h0000_0100, 32'hC0FF_EE5A);
    send_byte(8'h52);
    send_word(32'h0000_0100);
    for (int t = 0; t < 20 && !tx_valid_o; t++) @(negedge clk_i);
    chk("response pending", {31'b0, tx_valid_o}, 32'd1);
    repeat (20) @(negedge clk_i);
    chk("first byte still held", {24'b0, tx_data_o}, 32'h5A);
    tx_ready_i = 1'b1;
    wait_drain();

    // Reset in the middle of a write frame.
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h20);
    #2 rst_ni = 1'b0;
    #1 chk_reset_outputs("mid-frame reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    exp_bus.push_back('{1'b1, 32'h6050_4030, 32'hA1B2_C3D4});
    exp_tx.push_back(8'h06);
    send_byte(8'h57);
    send_word(32'h6050_4030);
    send_word(32'hA1B2_C3D4);
    wait_drain();

`ifdef UART_BRIDGE_TIMEOUT_EN
    // Stalled partial frame is dropped; the next 0x52 is a fresh command.
    send_byte(8'h52);
    send_byte(8'h00);
    repeat (110) @(negedge clk_i);
    expect_read(32'h1122_3344, 32'h0BAD_F00D);
    send_byte(8'h52);
    send_word(32'h1122_3344);
    wait_drain();
`endif

    chk("leftover tx expectations", exp_tx.size(), 32'd0);
    chk("leftover bus expectations", exp_bus.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
